// File: rtl/pl1r_sender_if.sv
// Burst request / PL1R line bundle between a controller (master) and pl1r_sender (slave).
interface pl1r_sender_if;
  logic       start;
  logic [3:0] burst_len;
  logic       abort;
  logic       DigOut;
  logic       busy;
  logic       done;
  logic [7:0] sent_cnt;

  modport master (
    output start, burst_len, abort,
    input  DigOut, busy, done, sent_cnt
  );

  modport slave (
    input  start, burst_len, abort,
    output DigOut, busy, done, sent_cnt
  );
endinterface

// File: rtl/pl1r_sender.sv
// PL1R burst sender: emits N pulses of PULSE_W high / GAP_W low cycles on DigOut,
// then a one-cycle FIN with done. abort returns to IDLE immediately.
module pl1r_sender #(
  parameter int PULSE_W = 8,
  parameter int GAP_W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  pl1r_sender_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, FIN} state_e;

  localparam logic [7:0] HIGH_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] LOW_LAST  = 8'(GAP_W - 1);

  state_e     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic [3:0] pcnt_q, pcnt_d;
  logic [3:0] len_q, len_d;
  logic [7:0] sent_q, sent_d;
  logic       dig_q, dig_d;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    pcnt_d  = pcnt_q;
    len_d   = len_q;
    sent_d  = sent_q;
    case (state_q)
      IDLE: begin
        // abort in IDLE outranks start: the request is dropped, not deferred
        if (bus.start && !bus.abort) begin
          state_d = HIGH;
          len_d   = (bus.burst_len == 4'd0) ? 4'd1 : bus.burst_len;
          pcnt_d  = 4'd0;
          wcnt_d  = 8'd0;
        end
      end
      HIGH: begin
        if (bus.abort) begin
          state_d = IDLE;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == HIGH_LAST) begin
          // pulse is counted as it enters its gap
          state_d = LOW;
          wcnt_d  = 8'd0;
          pcnt_d  = pcnt_q + 4'd1;
          sent_d  = sent_q + 8'd1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      LOW: begin
        if (bus.abort) begin
          state_d = IDLE;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == LOW_LAST) begin
          wcnt_d  = 8'd0;
          state_d = (pcnt_q < len_q) ? HIGH : FIN;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    dig_d = (state_d == HIGH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= 8'd0;
      pcnt_q  <= 4'd0;
      len_q   <= 4'd0;
      sent_q  <= 8'd0;
      dig_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
      len_q   <= len_d;
      sent_q  <= sent_d;
      dig_q   <= dig_d;
    end
  end

  assign bus.DigOut   = dig_q;
  assign bus.busy     = (state_q == HIGH) || (state_q == LOW);
  assign bus.done     = (state_q == FIN);
  assign bus.sent_cnt = sent_q;

endmodule

// File: tb/tb_pl1r_sender.sv
// Self-checking bench for pl1r_sender: directed scenarios plus random traffic
// compared against a burst-timeline reference model.
module tb_pl1r_sender;
  localparam int P  = 8;
  localparam int G  = 4;
  localparam int PG = P + G;

  logic clk = 1'b0;
  logic rst = 1'b0;
  pl1r_sender_if bus ();

  pl1r_sender #(.PULSE_W(P), .GAP_W(G)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a burst is described by its elapsed cycle t (1..n*PG) and length n.
  bit         m_active = 0;
  bit         m_fin    = 0;
  int         m_t      = 0;
  int         m_n      = 0;
  int         m_sent   = 0;
  logic       e_dig, e_busy, e_done;
  logic [7:0] e_sent;

  task automatic model_outputs();
    e_dig  = m_active && (((m_t - 1) % PG) < P);
    e_busy = m_active;
    e_done = m_fin;
    e_sent = 8'(m_sent);
  endtask

  task automatic model_reset();
    m_active = 0; m_fin = 0; m_t = 0; m_n = 0; m_sent = 0;
    model_outputs();
  endtask

  // Advance one clock: model consumes the inputs seen at the edge, outputs sampled at negedge.
  task automatic cyc();
    bit s, a;
    int len;
    @(posedge clk);
    s = bus.start; a = bus.abort; len = int'(bus.burst_len);
    if (!rst) model_reset();
    else if (m_fin) m_fin = 0;
    else if (m_active) begin
      if (a) m_active = 0;
      else if (m_t == m_n * PG) begin m_active = 0; m_fin = 1; end
      else begin
        m_t++;
        if (((m_t - 1) % PG) == P) m_sent = (m_sent + 1) % 256;
      end
    end else if (s && !a) begin
      m_active = 1; m_t = 1; m_n = (len == 0) ? 1 : len;
    end
    model_outputs();
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.start = 0; bus.abort = 0; bus.burst_len = 0;
    rst = 0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (bus.DigOut !== 1'b0) begin n_fail++; $display("FAIL reset_dig: got %b expected 0", bus.DigOut); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.sent_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", bus.sent_cnt); end
    rst = 1;
    cyc();
  endtask

  // One burst; checks the timeline against the model every cycle and the totals against constants.
  task automatic test_burst(input logic [3:0] len, input int exp_n);
    int high_cnt = 0, busy_cnt = 0, done_cnt = 0, done_at = -1, first_high = -1;
    int sent0 = int'(bus.sent_cnt);
    bus.start = 1; bus.burst_len = len;
    cyc();
    bus.start = 0; bus.burst_len = $urandom_range(0, 15);
    for (int c = 1; c <= exp_n * PG + 3; c++) begin
      n_checks++;
      if ({bus.DigOut, bus.busy, bus.done, bus.sent_cnt} !== {e_dig, e_busy, e_done, e_sent}) begin
        n_fail++;
        $display("FAIL burst_len%0d c%0d: got dig/busy/done/cnt %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 len, c, bus.DigOut, bus.busy, bus.done, bus.sent_cnt, e_dig, e_busy, e_done, e_sent);
      end
      if (bus.DigOut === 1'b1) begin high_cnt++; if (first_high < 0) first_high = c; end
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) begin done_cnt++; done_at = c; end
      cyc();
    end
    n_checks++; if (first_high !== 1) begin n_fail++; $display("FAIL latency_len%0d: got %0d expected 1", len, first_high); end
    n_checks++; if (high_cnt !== exp_n * P) begin n_fail++; $display("FAIL high_cycles_len%0d: got %0d expected %0d", len, high_cnt, exp_n * P); end
    n_checks++; if (busy_cnt !== exp_n * PG) begin n_fail++; $display("FAIL busy_cycles_len%0d: got %0d expected %0d", len, busy_cnt, exp_n * PG); end
    n_checks++; if (done_cnt !== 1 || done_at !== exp_n * PG + 1) begin
      n_fail++; $display("FAIL done_len%0d: got %0d pulses at %0d expected 1 at %0d", len, done_cnt, done_at, exp_n * PG + 1); end
    n_checks++; if (int'(bus.sent_cnt) !== (sent0 + exp_n) % 256) begin
      n_fail++; $display("FAIL sent_len%0d: got %0d expected %0d", len, bus.sent_cnt, (sent0 + exp_n) % 256); end
  endtask

  task automatic test_abort();
    int sent0 = int'(bus.sent_cnt), done_cnt = 0;
    bus.start = 1; bus.burst_len = 4'd4;
    cyc();
    bus.start = 0;
    for (int c = 1; c < 17; c++) cyc();
    // cycle 17 is the 5th high cycle of pulse 2
    n_checks++; if (bus.DigOut !== 1'b1) begin n_fail++; $display("FAIL abort_pre_dig: got %b expected 1", bus.DigOut); end
    bus.abort = 1;
    cyc();
    bus.abort = 0;
    n_checks++; if (bus.DigOut !== 1'b0) begin n_fail++; $display("FAIL abort_dig: got %b expected 0", bus.DigOut); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    for (int c = 0; c < 20; c++) begin
      if (bus.done === 1'b1) done_cnt++;
      n_checks++;
      if ({bus.DigOut, bus.busy, bus.done, bus.sent_cnt} !== {e_dig, e_busy, e_done, e_sent}) begin
        n_fail++; $display("FAIL abort_tail c%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", c,
                           bus.DigOut, bus.busy, bus.done, bus.sent_cnt, e_dig, e_busy, e_done, e_sent);
      end
      cyc();
    end
    n_checks++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt); end
    n_checks++; if (int'(bus.sent_cnt) !== (sent0 + 1) % 256) begin
      n_fail++; $display("FAIL abort_sent: got %0d expected %0d", bus.sent_cnt, (sent0 + 1) % 256); end
  endtask

  task automatic test_idle_controls();
    bus.start = 1; bus.abort = 1; bus.burst_len = 4'd2;
    cyc();
    bus.start = 0; bus.abort = 0;
    n_checks++; if (bus.busy !== 1'b0 || bus.DigOut !== 1'b0) begin
      n_fail++; $display("FAIL start_abort_idle: got busy/dig %b/%b expected 0/0", bus.busy, bus.DigOut); end
    // start and abort during FIN: FIN still ends, start is not taken
    bus.start = 1; bus.burst_len = 4'd1;
    cyc();
    bus.start = 0;
    for (int c = 1; c < PG + 1; c++) cyc();
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL fin_reached: got done %b expected 1", bus.done); end
    bus.start = 1; bus.abort = 1;
    cyc();
    bus.start = 0; bus.abort = 0;
    n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL fin_exit: got busy/done %b/%b expected 0/0", bus.busy, bus.done); end
    cyc();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fin_start_ignored: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_start_held();
    int done_at[$];
    int rise_at[$];
    logic prev_busy = 1'b0;
    bus.burst_len = 4'd1;
    for (int c = 0; c < 45; c++) begin
      bus.start = (c < 40);
      cyc();
      if (bus.done === 1'b1) done_at.push_back(c + 1);
      if (bus.busy === 1'b1 && prev_busy !== 1'b1) rise_at.push_back(c + 1);
      prev_busy = bus.busy;
    end
    bus.start = 0;
    n_checks++;
    if (done_at.size() !== 3 || done_at[0] !== 13 || done_at[1] !== 27 || done_at[2] !== 41) begin
      n_fail++; $display("FAIL held_done: got %0d pulses (%p) expected 3 at 13/27/41", done_at.size(), done_at); end
    n_checks++;
    if (rise_at.size() !== 3 || rise_at[0] !== 1 || rise_at[1] !== 15 || rise_at[2] !== 29) begin
      n_fail++; $display("FAIL held_accept: got %0d accepts (%p) expected busy rising at 1/15/29", rise_at.size(), rise_at); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.abort     = ($urandom_range(0, 39) == 0);
      bus.burst_len = 4'($urandom_range(0, 15));
      cyc();
      n_checks++;
      if ({bus.DigOut, bus.busy, bus.done, bus.sent_cnt} !== {e_dig, e_busy, e_done, e_sent}) begin
        n_fail++; $display("FAIL random c%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", c,
                           bus.DigOut, bus.busy, bus.done, bus.sent_cnt, e_dig, e_busy, e_done, e_sent);
      end
    end
    bus.start = 0; bus.abort = 0;
    for (int c = 0; c < 200; c++) cyc();
  endtask

  task automatic test_wrap_and_async_reset();
    rst = 0; cyc(); rst = 1; cyc();
    for (int b = 0; b < 256; b++) begin
      bus.start = 1; bus.burst_len = 4'd1;
      cyc();
      bus.start = 0;
      for (int c = 0; c < PG + 1; c++) cyc();
      if (b == 254) begin
        n_checks++; if (bus.sent_cnt !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d expected 255", bus.sent_cnt); end
      end
    end
    n_checks++; if (bus.sent_cnt !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d expected 0", bus.sent_cnt); end
    n_checks++; if (e_sent !== bus.sent_cnt) begin n_fail++; $display("FAIL wrap_model: got %0d expected %0d", bus.sent_cnt, e_sent); end
    // build a nonzero count, then reset in the middle of a high phase, between edges
    bus.start = 1; bus.burst_len = 4'd3;
    cyc();
    bus.start = 0;
    for (int c = 1; c < PG + 3; c++) cyc();
    n_checks++; if (bus.DigOut !== 1'b1 || bus.sent_cnt !== 8'd1) begin
      n_fail++; $display("FAIL pre_reset: got dig/cnt %b/%0d expected 1/1", bus.DigOut, bus.sent_cnt); end
    #2 rst = 0;
    #1;
    n_checks++; if (bus.DigOut !== 1'b0) begin n_fail++; $display("FAIL async_dig: got %b expected 0", bus.DigOut); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL async_done: got %b expected 0", bus.done); end
    n_checks++; if (bus.sent_cnt !== 8'd0) begin n_fail++; $display("FAIL async_cnt: got %0d expected 0", bus.sent_cnt); end
    model_reset();
    bus.start = 1; bus.burst_len = 4'd2;
    cyc();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_in_reset: got busy %b expected 0", bus.busy); end
    rst = 1;
    cyc();
    bus.start = 0;
    n_checks++; if (bus.busy !== 1'b1 || bus.DigOut !== 1'b1) begin
      n_fail++; $display("FAIL first_start_after_reset: got busy/dig %b/%b expected 1/1", bus.busy, bus.DigOut); end
    for (int c = 0; c < 2 * PG + 2; c++) begin
      n_checks++;
      if ({bus.DigOut, bus.busy, bus.done, bus.sent_cnt} !== {e_dig, e_busy, e_done, e_sent}) begin
        n_fail++; $display("FAIL post_reset c%0d: got %b/%b/%b/%0d expected %b/%b/%b/%0d", c,
                           bus.DigOut, bus.busy, bus.done, bus.sent_cnt, e_dig, e_busy, e_done, e_sent);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_burst(4'd1, 1);
    test_burst(4'd3, 3);
    test_burst(4'd0, 1);
    test_burst(4'd15, 15);
    test_abort();
    test_idle_controls();
    test_start_held();
    test_random();
    test_wrap_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
